// File: rtl/laser_link_bist.sv
// PRBS built-in self-test for the optical link: drives per-channel LFSR frames to the
// serializers, checks the words coming back from the deserializers and counts mismatches.
module laser_link_bist #(
  parameter int          NUM_CH    = 2,
  parameter int          DATA_W    = 8,
  parameter int          FRAME_LEN = 16,
  parameter int          TIMEOUT   = 4096,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  input  logic [NUM_CH-1:0]        rx_valid,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [NUM_CH*16-1:0]     err_count,
  output logic [1:0]               bist_state
);
  // Handshake: a TX word moves on every cycle with tx_valid && tx_ready, and tx_valid/tx_data
  // hold until that happens. rx_valid[c] is a one-cycle strobe with no backpressure.
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam int          CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int          IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] SEED2  = {SEED, SEED};

  state_t            state, state_next;
  logic [15:0]       tx_lfsr [NUM_CH];
  logic [15:0]       rx_lfsr [NUM_CH];
  logic [15:0]       tx_step [NUM_CH];
  logic [15:0]       rx_step [NUM_CH];
  logic [15:0]       seed    [NUM_CH];
  logic [CNT_W-1:0]  rx_cnt  [NUM_CH];
  logic [CNT_W-1:0]  tx_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              all_rx_done, any_err, complete, idle_hit, xfer, last_tx;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign bist_state = state;

  // Channel c seed is SEED rotated left by c, taken as a window of the doubled seed.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      seed[c]    = SEED2[31-c -: 16];
      tx_step[c] = lfsr_next(tx_lfsr[c]);
      rx_step[c] = lfsr_next(rx_lfsr[c]);
    end
  end

  always_comb begin
    all_rx_done = 1'b1;
    any_err     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rx_cnt[c] != CNT_W'(FRAME_LEN)) all_rx_done = 1'b0;
      if (err_count[c*16 +: 16] != 16'd0) any_err = 1'b1;
    end
    xfer       = tx_valid && tx_ready;
    last_tx    = xfer && (tx_cnt == CNT_W'(FRAME_LEN - 1));
    complete   = (state == WAIT) && all_rx_done;
    idle_hit   = (idle_cnt == IDLE_W'(TIMEOUT));
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = SEND;
      SEND: begin
        if (idle_hit)     state_next = DONE;
        else if (last_tx) state_next = WAIT;
      end
      WAIT:    if (complete || idle_hit) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      tx_cnt    <= '0;
      idle_cnt  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tx_lfsr[c] <= seed[c];
        rx_lfsr[c] <= seed[c];
        rx_cnt[c]  <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            tx_cnt    <= '0;
            idle_cnt  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              tx_lfsr[c]                   <= seed[c];
              rx_lfsr[c]                   <= seed[c];
              rx_cnt[c]                    <= '0;
              tx_data[c*DATA_W +: DATA_W]  <= seed[c][DATA_W-1:0];
            end
          end
        end
        SEND, WAIT: begin
          idle_cnt <= (|rx_valid) ? '0 : idle_cnt + 1'b1;
          if (xfer) begin
            tx_cnt <= tx_cnt + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
              tx_lfsr[c]                  <= tx_step[c];
              tx_data[c*DATA_W +: DATA_W] <= tx_step[c][DATA_W-1:0];
            end
          end
          // RX LFSRs advance per received word, so early words are checked in order too.
          for (int c = 0; c < NUM_CH; c++) begin
            if (rx_valid[c] && (rx_cnt[c] < CNT_W'(FRAME_LEN))) begin
              rx_lfsr[c] <= rx_step[c];
              rx_cnt[c]  <= rx_cnt[c] + 1'b1;
              if ((rx_data[c*DATA_W +: DATA_W] != rx_lfsr[c][DATA_W-1:0]) &&
                  (err_count[c*16 +: 16] != 16'hFFFF))
                err_count[c*16 +: 16] <= err_count[c*16 +: 16] + 16'd1;
            end
          end
          if (state_next == DONE) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            tx_valid <= 1'b0;
            pass     <= complete && !any_err;
            timeout  <= !complete;
          end else if (last_tx) begin
            tx_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_link_bist.sv
// Bench for laser_link_bist: loopback frames with random backpressure and corruption, checked
// against a PRBS sequence model and a mismatch-count model built from the link rules.
`timescale 1ns/1ps
module tb_laser_link_bist;
  localparam int          NUM_CH    = 2;
  localparam int          DATA_W    = 8;
  localparam int          FRAME_LEN = 16;
  localparam int          TIMEOUT   = 4096;
  localparam int          BUDGET    = 6000;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic                     tx_ready = 1'b0;
  logic                     tx_valid;
  logic [NUM_CH*DATA_W-1:0] tx_data;
  logic [NUM_CH-1:0]        rx_valid = '0;
  logic [NUM_CH*DATA_W-1:0] rx_data = '0;
  logic                     busy, done, pass, timeout;
  logic [NUM_CH*16-1:0]     err_count;
  logic [1:0]               bist_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q [NUM_CH][$];
  logic [DATA_W-1:0] exp_words [NUM_CH][FRAME_LEN];
  logic [DATA_W-1:0] flips [NUM_CH][FRAME_LEN];
  int                exp_err [NUM_CH];
  int                cfg_rand_ready, cfg_stall_at, cfg_stall_len, cfg_start_spam;
  logic [NUM_CH-1:0] cfg_rx_en;
  int                run_cycles, last_rx_n;
  logic [NUM_CH*DATA_W-1:0] first_tx;

  laser_link_bist #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN),
                    .TIMEOUT(TIMEOUT), .SEED(SEED)) dut (
    .clock(clock), .reset(reset), .start(start), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .bist_state(bist_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // PRBS x^16+x^14+x^13+x^11+1: feedback is the parity of the tapped bits.
  function automatic logic [15:0] prbs_next(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic logic [15:0] seed_of(input int c);
    logic [31:0] dd;
    dd = {SEED, SEED} >> (16 - c);
    return dd[15:0];
  endfunction

  task automatic load_model();
    logic [15:0] s;
    for (int c = 0; c < NUM_CH; c++) begin
      s = seed_of(c);
      exp_q[c].delete();
      exp_err[c] = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        exp_words[c][i] = s[DATA_W-1:0];
        exp_q[c].push_back(s[DATA_W-1:0]);
        s = prbs_next(s);
      end
    end
  endtask

  task automatic clear_cfg();
    cfg_rand_ready = 0;
    cfg_stall_at   = -1;
    cfg_stall_len  = 0;
    cfg_start_spam = 0;
    cfg_rx_en      = '1;
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < FRAME_LEN; i++) flips[c][i] = '0;
  endtask

  // Loopback driver: each transferred word returns one cycle later, optionally corrupted.
  task automatic run_frame();
    int n, txn, stall_left, stalled;
    logic xfer;
    logic [NUM_CH*DATA_W-1:0] xdata;
    logic [DATA_W-1:0] word;
    load_model();
    tx_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    first_tx = tx_data;
    n = 0; txn = 0; stall_left = 0; stalled = 0; last_rx_n = -1;
    while (done !== 1'b1 && n < BUDGET) begin
      if (!stalled && cfg_stall_at >= 0 && txn == cfg_stall_at) begin
        stall_left = cfg_stall_len;
        stalled = 1;
      end
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else if (cfg_rand_ready != 0) tx_ready = ($urandom_range(0, 3) != 0);
      else tx_ready = 1'b1;
      if (cfg_start_spam != 0) start = ($urandom_range(0, 3) == 0);
      checks++;
      if (tx_valid !== (txn < FRAME_LEN))
        begin errors++; $display("FAIL tx_valid word %0d: got %b want %b", txn, tx_valid, txn < FRAME_LEN); end
      if (txn < FRAME_LEN) begin
        for (int c = 0; c < NUM_CH; c++) begin
          checks++;
          if (tx_data[c*DATA_W +: DATA_W] !== exp_q[c][0])
            begin errors++; $display("FAIL tx_data ch%0d word %0d: got %h want %h", c, txn, tx_data[c*DATA_W +: DATA_W], exp_q[c][0]); end
        end
      end
      xfer  = (tx_valid === 1'b1) && tx_ready;
      xdata = tx_data;
      cycle();
      n++;
      start = 1'b0;
      rx_valid = '0;
      if (xfer && txn < FRAME_LEN) begin
        for (int c = 0; c < NUM_CH; c++) begin
          void'(exp_q[c].pop_front());
          word = xdata[c*DATA_W +: DATA_W] ^ flips[c][txn];
          rx_data[c*DATA_W +: DATA_W] = word;
          if (cfg_rx_en[c] && word !== exp_words[c][txn]) exp_err[c]++;
        end
        rx_valid = cfg_rx_en;
        if (cfg_rx_en != '0) last_rx_n = n;
        txn++;
      end
    end
    rx_valid = '0;
    run_cycles = n;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL run_budget: done=%b after %0d cycles want 1", done, n); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({tx_valid, busy, done, pass, timeout} !== 5'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 00000", {tx_valid, busy, done, pass, timeout}); end
    checks++;
    if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    checks++;
    if (err_count !== '0) begin errors++; $display("FAIL reset_err_count: got %h want 0", err_count); end
    checks++;
    if (bist_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0 (IDLE)", bist_state); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_loopback();
    clear_cfg();
    run_frame();
    checks++;
    if (first_tx[7:0] !== 8'hE1) begin errors++; $display("FAIL first_word_ch0: got %h want e1", first_tx[7:0]); end
    checks++;
    if (first_tx[15:8] !== 8'hC3) begin errors++; $display("FAIL first_word_ch1: got %h want c3", first_tx[15:8]); end
    checks++;
    if (run_cycles !== 18) begin errors++; $display("FAIL loopback_latency: got %0d want 18", run_cycles); end
    checks++;
    if ({busy, pass, timeout} !== 3'b010) begin errors++; $display("FAIL loopback_result busy/pass/timeout: got %b want 010", {busy, pass, timeout}); end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (err_count[c*16 +: 16] !== 16'(exp_err[c]) || exp_err[c] != 0)
        begin errors++; $display("FAIL loopback_err ch%0d: got %0d want 0", c, err_count[c*16 +: 16]); end
    end
  endtask

  task automatic test_error();
    clear_cfg();
    flips[1][5] = 8'h01;
    run_frame();
    checks++;
    if ({pass, timeout} !== 2'b00) begin errors++; $display("FAIL error_result pass/timeout: got %b want 00", {pass, timeout}); end
    checks++;
    if (err_count[15:0] !== 16'd0) begin errors++; $display("FAIL error_ch0: got %0d want 0", err_count[15:0]); end
    checks++;
    if (err_count[31:16] !== 16'd1) begin errors++; $display("FAIL error_ch1: got %0d want 1", err_count[31:16]); end
  endtask

  task automatic test_random();
    logic exp_pass;
    for (int it = 0; it < 4; it++) begin
      clear_cfg();
      cfg_rand_ready = 1;
      cfg_start_spam = 1;
      for (int k = 0; k < it; k++)
        flips[$urandom_range(0, NUM_CH-1)][$urandom_range(0, FRAME_LEN-1)] = DATA_W'($urandom_range(1, 255));
      run_frame();
      exp_pass = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (exp_err[c] != 0) exp_pass = 1'b0;
        checks++;
        if (err_count[c*16 +: 16] !== 16'(exp_err[c]))
          begin errors++; $display("FAIL random%0d_err ch%0d: got %0d want %0d", it, c, err_count[c*16 +: 16], exp_err[c]); end
      end
      checks++;
      if ({done, pass, timeout} !== {1'b1, exp_pass, 1'b0})
        begin errors++; $display("FAIL random%0d_result done/pass/timeout: got %b want %b", it, {done, pass, timeout}, {1'b1, exp_pass, 1'b0}); end
    end
  endtask

  task automatic test_timeout();
    clear_cfg();
    cfg_rx_en = 2'b10;
    run_frame();
    checks++;
    if ({done, pass, timeout} !== 3'b101) begin errors++; $display("FAIL timeout_result done/pass/timeout: got %b want 101", {done, pass, timeout}); end
    checks++;
    if (run_cycles - last_rx_n - 1 !== TIMEOUT + 1)
      begin errors++; $display("FAIL timeout_gap (idle cycles + 1 result cycle): got %0d want %0d", run_cycles - last_rx_n - 1, TIMEOUT + 1); end
    checks++;
    if (err_count !== '0) begin errors++; $display("FAIL timeout_err: got %h want 0", err_count); end
  endtask

  task automatic test_stall();
    clear_cfg();
    cfg_stall_at  = 6;
    cfg_stall_len = 10;
    run_frame();
    checks++;
    if (run_cycles !== 28) begin errors++; $display("FAIL stall_latency: got %0d want 28", run_cycles); end
    checks++;
    if ({pass, timeout} !== 2'b10 || err_count !== '0)
      begin errors++; $display("FAIL stall_result pass/timeout/err: got %b/%h want 10/0", {pass, timeout}, err_count); end
  endtask

  task automatic test_reset_mid();
    clear_cfg();
    load_model();
    tx_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (7) cycle();
    checks++;
    if (tx_data[DATA_W-1:0] !== exp_words[0][7])
      begin errors++; $display("FAIL midrun_word7: got %h want %h", tx_data[DATA_W-1:0], exp_words[0][7]); end
    reset = 1'b1;
    cycle();
    checks++;
    if ({tx_valid, busy, done, pass, timeout} !== 5'b0 || tx_data !== '0 || err_count !== '0 || bist_state !== 2'd0)
      begin errors++; $display("FAIL midrun_reset: flags %b tx %h err %h state %0d want all 0", {tx_valid, busy, done, pass, timeout}, tx_data, err_count, bist_state); end
    reset = 1'b0;
    cycle();
    run_frame();
    checks++;
    if ({pass, timeout} !== 2'b10 || err_count !== '0 || first_tx[7:0] !== 8'hE1)
      begin errors++; $display("FAIL after_reset_run pass/timeout/err/first: got %b/%h/%h want 10/0/e1", {pass, timeout}, err_count, first_tx[7:0]); end
  endtask

  task automatic test_rx_early();
    int n;
    clear_cfg();
    load_model();
    tx_ready = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        rx_data[c*DATA_W +: DATA_W] = exp_words[c][i] ^ ((c == 0 && i == 3) ? 8'h80 : 8'h00);
      rx_valid = '1;
      cycle();
    end
    rx_valid = '0;
    checks++;
    if (tx_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL early_hold tx_valid/done: got %b%b want 10", tx_valid, done); end
    tx_ready = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin cycle(); n++; end
    checks++;
    if ({done, pass, timeout} !== 3'b100) begin errors++; $display("FAIL early_result done/pass/timeout: got %b want 100", {done, pass, timeout}); end
    checks++;
    if (err_count !== {16'd0, 16'd1}) begin errors++; $display("FAIL early_err: got %h want 00000001", err_count); end
  endtask

  task automatic test_back_to_back();
    clear_cfg();
    cfg_start_spam = 1;
    run_frame();
    checks++;
    if (run_cycles !== 18) begin errors++; $display("FAIL busy_start_latency: got %0d want 18", run_cycles); end
    for (int k = 0; k < 3; k++) begin
      rx_valid = '1;
      rx_data = NUM_CH*DATA_W'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    rx_valid = '0;
    cycle();
    checks++;
    if ({done, pass, busy, tx_valid} !== 4'b1100 || err_count !== '0)
      begin errors++; $display("FAIL extra_words done/pass/busy/tx_valid/err: got %b/%h want 1100/0", {done, pass, busy, tx_valid}, err_count); end
    checks++;
    if (bist_state !== 2'd3) begin errors++; $display("FAIL extra_words_state: got %0d want 3 (DONE)", bist_state); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_error();
    test_stall();
    test_reset_mid();
    test_rx_early();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
